mod_mult_serial: RTL and testbench

- Digit-serial modular multiplier: computes z = (a * b) mod MOD, one radix-2^D digit of a per clock, Horner form from MSB down.
- Parametrised, sequential successor to the fixed single-digit constant-product LUT blocks of the mod-107 datapath.
- Sits between operand registers and the residue accumulator; valid/ready on both sides.

---
 rtl/mod_mult_serial_if.sv | 37 +++
 rtl/mod_mult_serial.sv | 136 +++++++++++++
 tb/tb_mod_mult_serial.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mod_mult_serial_if.sv
// Operand/result handshake bundle for mod_mult_serial.
// The out_err signal exists only when MODMUL_RANGE_CHECK_EN is defined.
interface mod_mult_serial_if #(
  parameter int W = 7
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic         busy;
`ifdef MODMUL_RANGE_CHECK_EN
  logic         out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_z, busy, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_z, busy, out_err
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_z, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_z, busy
  );
`endif
endinterface

// File: rtl/mod_mult_serial.sv
// Digit-serial modular multiplier: z = (a*b) mod MOD, one radix-2^D digit of a per cycle, MSB first.
// Define MODMUL_RANGE_CHECK_EN to flag operands >= MOD through out_err (result forced to 0).
module mod_mult_serial #(
  parameter int MOD = 107,
  parameter int W   = 7,
  parameter int D   = 3
) (
  input  logic             clk,
  input  logic             rst,
  mod_mult_serial_if.slave bus
);

  localparam int NDIG = (W + D - 1) / D;
  localparam int AW   = NDIG * D;
  localparam int SW   = W + D + 1;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
  localparam logic [SW-1:0] MOD_S    = SW'(MOD);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] a_sh_q,  a_sh_d;
  logic [W-1:0]  b_q,     b_d;
  logic [W-1:0]  acc_q,   acc_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  out_z_q, out_z_d;

  logic [D-1:0]  dig;
  logic [SW-1:0] sum;
  logic [SW-1:0] red;
  logic [W-1:0]  acc_next;

`ifdef MODMUL_RANGE_CHECK_EN
  logic err_q, err_d;
  logic bad_operands;

  assign bad_operands = (bus.in_a >= W'(MOD)) || (bus.in_b >= W'(MOD));
`endif

  assign dig = a_sh_q[AW-1 -: D];

  // Horner step acc*2^D + dig*b stays below 2^(D+1)*MOD, so D+1 conditional
  // subtractions of MOD*2^k (k = D..0) fully reduce it in one cycle.
  always_comb begin
    sum = {1'b0, acc_q, {D{1'b0}}} + (SW'(dig) * SW'(b_q));
    red = sum;
    for (int k = D; k >= 0; k--) begin
      if (red >= (MOD_S << k)) begin
        red = red - (MOD_S << k);
      end
    end
    acc_next = W'(red);
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_z_d = out_z_q;
`ifdef MODMUL_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = AW'(bus.in_a);
          b_d     = bus.in_b;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef MODMUL_RANGE_CHECK_EN
          err_d   = bad_operands;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d  = acc_next;
        a_sh_d = a_sh_q << D;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
`ifdef MODMUL_RANGE_CHECK_EN
          out_z_d = err_q ? '0 : acc_next;
`else
          out_z_d = acc_next;
`endif
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_z_q <= '0;
`ifdef MODMUL_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_z_q <= out_z_d;
`ifdef MODMUL_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_z     = out_z_q;
`ifdef MODMUL_RANGE_CHECK_EN
  assign bus.out_err   = (state_q == ST_DONE) && err_q;
`endif

endmodule

// File: tb/tb_mod_mult_serial.sv
// Scoreboard bench for mod_mult_serial: directed corner cases plus a random sweep
// against (a*b) % MOD; range-check cases are compiled in with MODMUL_RANGE_CHECK_EN.
module tb_mod_mult_serial;

  localparam int MOD  = 107;
  localparam int W    = 7;
  localparam int D    = 3;
  localparam int NDIG = (W + D - 1) / D;

  typedef struct {
    int z;
    int err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  exp_t exp_q[$];
  int   pass_count  = 0;
  int   check_count = 0;

  mod_mult_serial_if #(.W(W)) bus ();

  mod_mult_serial #(
    .MOD(MOD),
    .W  (W),
    .D  (D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic exp_t refModel(input int a, input int b);
    exp_t e;
    e.err = 0;
`ifdef MODMUL_RANGE_CHECK_EN
    if (a >= MOD || b >= MOD) e.err = 1;
`endif
    e.z = (e.err != 0) ? 0 : (a * b) % MOD;
    return e;
  endfunction

  // Monitor: every output handshake pops one expectation from the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checkOutput("result_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("out_z", int'(bus.out_z), e.z);
`ifdef MODMUL_RANGE_CHECK_EN
        checkOutput("out_err", int'(bus.out_err), e.err);
`endif
      end
    end
  end

  task automatic applyStimulus(input int a, input int b, input int hold);
    int   waited  = 0;
    int   lat     = 0;
    bit   busy_ok = 1'b1;
    bit   hold_ok = 1'b1;
    exp_t e;
    e = refModel(a, b);
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("in_ready_before_issue", int'(bus.in_ready), 1);
    bus.in_a     = W'(a);
    bus.in_b     = W'(b);
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 4 * NDIG + 4) begin
      if (!bus.busy || bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, NDIG);
    if (!bus.busy || bus.in_ready) busy_ok = 1'b0;
    checkOutput("busy_no_ready_while_active", int'(busy_ok), 1);
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = i[0];
        bus.in_a     = W'($urandom_range(0, MOD - 1));
        bus.in_b     = W'($urandom_range(0, MOD - 1));
        @(posedge clk); #1;
        if (!bus.out_valid || bus.in_ready || int'(bus.out_z) != e.z) hold_ok = 1'b0;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      checkOutput("stable_under_backpressure", int'(hold_ok), 1);
    end
    @(posedge clk); #1;
    checkOutput("idle_after_handshake", int'(bus.in_ready && !bus.out_valid && !bus.busy), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got %0d queued, expected 0", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit stale_ok;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", int'(bus.in_ready), 1);
    checkOutput("reset_out_valid", int'(bus.out_valid), 0);
    checkOutput("reset_out_z", int'(bus.out_z), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
`ifdef MODMUL_RANGE_CHECK_EN
    checkOutput("reset_out_err", int'(bus.out_err), 0);
`endif
    rst = 1'b0;

    applyStimulus(5, 9, 0);
    applyStimulus(100, 106, 0);
    applyStimulus(106, 106, 0);
    applyStimulus(84, 5, 0);
    applyStimulus(0, 73, 0);
    applyStimulus(1, 73, 0);
    applyStimulus(73, 1, 0);
    applyStimulus(MOD - 1, 0, 0);
    applyStimulus(84, 5, 10);

    // Abort an operation with reset one cycle after it was accepted.
    bus.in_a     = W'(50);
    bus.in_b     = W'(60);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_in_ready", int'(bus.in_ready), 1);
    checkOutput("abort_out_valid", int'(bus.out_valid), 0);
    checkOutput("abort_out_z", int'(bus.out_z), 0);
    checkOutput("abort_busy", int'(bus.busy), 0);
    stale_ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) stale_ok = 1'b0;
    end
    checkOutput("no_stale_result", int'(stale_ok), 1);
    applyStimulus(2, 3, 0);

`ifdef MODMUL_RANGE_CHECK_EN
    applyStimulus(110, 3, 0);
    applyStimulus(2, 3, 0);
    applyStimulus(4, 127, 2);
    applyStimulus(106, 106, 0);
`endif

    for (int n = 0; n < 1500; n++) begin
      int a;
      int b;
      int hold;
      a    = $urandom_range(0, MOD - 1);
      b    = $urandom_range(0, MOD - 1);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(a, b, hold);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
